// File: rtl/candy_mem.sv
// Memory-access stage: retires ALU/STORE ops in one cycle and waits on a
// variable-latency SRAM read port for LOADs, with a bounded timeout.
module candy_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [1:0]        ex_op,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [REG_AW-1:0] ex_reg_addr,
  output logic              sram_re,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_rvalid,
  output logic              wb_enable,
  output logic              is_mem,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] sram_result_addr,
  output logic [REG_AW-1:0] reg_addr,
  output logic              mem_err
);

  // Handshake: an op transfers on a rising clk edge where ex_valid && ex_ready;
  // ex_ready is high exactly while the FSM is IDLE.
  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  localparam logic [1:0] OP_ALU   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [7:0] LIMIT    = 8'(TIMEOUT - 1);

  state_t              state, state_d;
  logic [7:0]          cnt, cnt_d;
  logic [REG_AW-1:0]   dest, dest_d;
  logic                wb_d, is_mem_d, re_d, err_d;
  logic [DATA_W-1:0]   result_d;
  logic [ADDR_W-1:0]   saddr_d, raddr_d;
  logic [REG_AW-1:0]   reg_d;
  logic                accept;

  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid && ex_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      dest             <= '0;
      wb_enable        <= 1'b0;
      is_mem           <= 1'b0;
      sram_re          <= 1'b0;
      mem_err          <= 1'b0;
      result           <= '0;
      sram_result_addr <= '0;
      reg_addr         <= '0;
      sram_raddr       <= '0;
    end else begin
      state            <= state_d;
      cnt              <= cnt_d;
      dest             <= dest_d;
      wb_enable        <= wb_d;
      is_mem           <= is_mem_d;
      sram_re          <= re_d;
      mem_err          <= err_d;
      result           <= result_d;
      sram_result_addr <= saddr_d;
      reg_addr         <= reg_d;
      sram_raddr       <= raddr_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    dest_d   = dest;
    wb_d     = 1'b0;
    re_d     = 1'b0;
    is_mem_d = is_mem;
    err_d    = mem_err;
    result_d = result;
    saddr_d  = sram_result_addr;
    reg_d    = reg_addr;
    raddr_d  = sram_raddr;
    case (state)
      IDLE: begin
        if (accept) begin
          case (ex_op)
            OP_ALU: begin
              wb_d     = 1'b1;
              is_mem_d = 1'b0;
              result_d = ex_result;
              reg_d    = ex_reg_addr;
            end
            OP_STORE: begin
              wb_d     = 1'b1;
              is_mem_d = 1'b1;
              result_d = ex_result;
              saddr_d  = ex_addr;
            end
            OP_LOAD: begin
              re_d    = 1'b1;
              raddr_d = ex_addr;
              dest_d  = ex_reg_addr;
              cnt_d   = '0;
              state_d = WAIT;
            end
            default: ;
          endcase
        end
      end
      WAIT: begin
        // The request cycle itself cannot carry a response; rvalid beats the timeout.
        if (sram_rvalid && !sram_re) begin
          wb_d     = 1'b1;
          is_mem_d = 1'b0;
          result_d = sram_rdata;
          reg_d    = dest;
          state_d  = IDLE;
        end else if (cnt == LIMIT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt != 8'hFF) begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
